instruction_fetch: RTL

- Fetch stage of the MIPS-style CPU, directly upstream of the instruction memory.
- Holds the program counter and drives the word-aligned byte address into instruction memory.
- Captures the returned 32-bit instruction into the IF/ID pipeline register consumed by decode.
- Handles stall, branch/jump redirect with bubble insertion, and out-of-range fetch protection.

---
 rtl/instruction_fetch.sv | 62 ++++++
 1 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, imem addressing and IF/ID register with stall, redirect and out-of-range handling
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  output logic [31:0] pc,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc_plus4,
  output logic        ifid_valid,
  output logic        misalign,
  output logic        oob,
  output logic [31:0] fetch_count
);
  localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) << 2;
  logic        redirect;
  logic        in_range;
  logic [31:0] target;
  logic [31:0] pc_plus4;
  assign redirect  = branch_taken | jump;
  assign target    = branch_taken ? branch_target : jump_target;
  assign pc_plus4  = pc + 32'd4;
  assign in_range  = {1'b0, pc} < LIMIT;
  assign imem_addr = pc;
  always_ff @(posedge clk) begin
    if (rst) begin
      pc            <= {RESET_PC[31:2], 2'b00};
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
      misalign      <= 1'b0;
      oob           <= 1'b0;
      fetch_count   <= '0;
    end else if (redirect) begin
      pc            <= {target[31:2], 2'b00};
      misalign      <= |target[1:0];
      ifid_instr    <= '0;
      ifid_pc_plus4 <= '0;
      ifid_valid    <= 1'b0;
      oob           <= 1'b0;
    end else if (stall) begin
      misalign      <= 1'b0;
      oob           <= 1'b0;
    end else begin
      pc            <= pc_plus4;
      ifid_pc_plus4 <= pc_plus4;
      ifid_instr    <= in_range ? imem_instr : 32'd0;
      ifid_valid    <= in_range;
      fetch_count   <= fetch_count + 32'(in_range);
      oob           <= ~in_range;
      misalign      <= 1'b0;
    end
  end
endmodule
